// File: rtl/watchdog_monitor_pkg.sv
// watchdog_monitor_pkg: shared state encodings and strobe timing defaults
package watchdog_monitor_pkg;
  typedef enum logic [1:0] {ACQ = 2'd0, LOCK = 2'd1, OK = 2'd2, FAULT = 2'd3} wd_state_t;
  localparam int NOM_PERIOD_DEF = 251;
  localparam int TOL_DEF = 4;
endpackage

// File: rtl/wd_rise_detect.sv
// wd_rise_detect: registers the watchdog strobe and flags its rising edge
// Ports: adc_clk clock, rst sync reset, wd_stp strobe in, rise 1 on a 0->1 transition
module wd_rise_detect (
  input  logic adc_clk,
  input  logic rst,
  input  logic wd_stp,
  output logic rise
);
  logic stp_d;
  always_ff @(posedge adc_clk) stp_d <= rst ? 1'b0 : wd_stp;
  assign rise = wd_stp & ~stp_d;
endmodule

// File: rtl/watchdog_monitor.sv
// watchdog_monitor: checks presence and period of the periodic watchdog strobe
// Ports: adc_clk clock, rst sync active-high reset, wd_stp strobe, clr_fault leave FAULT,
//        wd_ok state OK, wd_fault state FAULT, wd_miss bad/missing period pulse,
//        wd_period last measured gap, wd_state FSM state.
// Build option: WD_EARLY_CHECK_EN also rejects strobes arriving earlier than NOM_PERIOD-TOL.
module watchdog_monitor
  import watchdog_monitor_pkg::*;
#(
  parameter int NOM_PERIOD = NOM_PERIOD_DEF,
  parameter int TOL        = TOL_DEF,
  parameter int LOCK_CNT   = 4,
  parameter int MISS_LIMIT = 2,
  parameter int PW         = 9
) (
  input  logic          adc_clk,
  input  logic          rst,
  input  logic          wd_stp,
  input  logic          clr_fault,
  output logic          wd_ok,
  output logic          wd_fault,
  output logic          wd_miss,
  output logic [PW-1:0] wd_period,
  output logic [1:0]    wd_state
);
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int MW = $clog2(MISS_LIMIT + 1);
  localparam logic [PW-1:0] HI = PW'(NOM_PERIOD + TOL);
  localparam logic [PW-1:0] CMAX = '1;
  wd_state_t state, state_n;
  logic [PW-1:0] cnt, cnt_n, period_n;
  logic [GW-1:0] good, good_n;
  logic [MW-1:0] miss, miss_n;
  logic rise, timeout, in_win, bad, miss_p_n;
  wd_rise_detect u_rise (.adc_clk(adc_clk), .rst(rst), .wd_stp(wd_stp), .rise(rise));
  // A strobe landing exactly on the timeout cycle wins over the virtual strobe.
  assign timeout = ~rise & (cnt == HI);
`ifdef WD_EARLY_CHECK_EN
  localparam logic [PW-1:0] LO = PW'(NOM_PERIOD - TOL);
  assign in_win = (cnt >= LO) & (cnt <= HI);
`else
  assign in_win = cnt <= HI;
`endif
  assign bad = (rise & ~in_win) | timeout;
  always_comb begin
    state_n = state;
    good_n = good;
    miss_n = miss;
    miss_p_n = 1'b0;
    cnt_n = (rise | timeout) ? PW'(1) : (cnt == CMAX ? cnt : cnt + 1'b1);
    period_n = (rise & (state == LOCK | state == OK)) ? cnt : wd_period;
    unique case (state)
      ACQ: if (rise) begin
        state_n = LOCK;
        good_n = '0;
      end
      LOCK: if (rise & in_win) begin
        good_n = good + GW'(good != GW'(LOCK_CNT));
        if (good_n == GW'(LOCK_CNT)) begin
          state_n = OK;
          miss_n = '0;
        end
      end else if (bad) begin
        good_n = '0;
        miss_p_n = 1'b1;
      end
      OK: if (rise & in_win) miss_n = '0;
      else if (bad) begin
        miss_p_n = 1'b1;
        miss_n = miss + MW'(miss != MW'(MISS_LIMIT));
        if (miss_n == MW'(MISS_LIMIT)) state_n = FAULT;
      end
      FAULT: if (clr_fault) begin
        state_n = ACQ;
        cnt_n = PW'(1);
        good_n = '0;
        miss_n = '0;
      end
    endcase
  end
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state <= ACQ;
      cnt <= PW'(1);
      good <= '0;
      miss <= '0;
      wd_miss <= 1'b0;
      wd_period <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      good <= good_n;
      miss <= miss_n;
      wd_miss <= miss_p_n;
      wd_period <= period_n;
    end
  end
  assign wd_ok = state == OK;
  assign wd_fault = state == FAULT;
  assign wd_state = state;
endmodule

// File: tb/tb_watchdog_monitor.sv
// tb_watchdog_monitor: directed and randomized checks of watchdog_monitor against a timeline model
module tb_watchdog_monitor;
  localparam int HI = 255, LO = 247, LOCKN = 4, MISSN = 2;
  localparam int S_ACQ = 0, S_LOCK = 1, S_OK = 2, S_FAULT = 3;
`ifdef WD_EARLY_CHECK_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  logic adc_clk = 1'b0, rst = 1'b0, wd_stp = 1'b0, clr_fault = 1'b0;
  logic wd_ok, wd_fault, wd_miss;
  logic [8:0] wd_period;
  logic [1:0] wd_state;
  int checks = 0, errors = 0;
  int cyc = 0, m_state = 0, m_last = 0, m_good = 0, m_miss = 0, m_period = 0;
  bit m_prev = 0, m_pulse = 0;
  int miss_q[$];
  watchdog_monitor dut (
    .adc_clk(adc_clk), .rst(rst), .wd_stp(wd_stp), .clr_fault(clr_fault),
    .wd_ok(wd_ok), .wd_fault(wd_fault), .wd_miss(wd_miss),
    .wd_period(wd_period), .wd_state(wd_state)
  );
  always #5 adc_clk = ~adc_clk;
  // Model: time since the last real or virtual strobe, measured in edges.
  task automatic step(input bit s, input bit c, input bit r);
    bit rise, to, good_r;
    int gap, old;
    wd_stp = s;
    clr_fault = c;
    rst = r;
    @(posedge adc_clk);
    cyc++;
    rise = s && !m_prev;
    m_prev = r ? 1'b0 : s;
    gap = cyc - m_last;
    to = !rise && gap == HI;
    good_r = rise && gap <= HI && (!EARLY || gap >= LO);
    old = m_state;
    m_pulse = 0;
    if (r) begin
      m_state = S_ACQ; m_last = cyc; m_good = 0; m_miss = 0; m_period = 0;
    end else begin
      if (rise && (old == S_LOCK || old == S_OK)) m_period = gap;
      if (rise || to) m_last = cyc;
      if (old == S_ACQ && rise) begin
        m_state = S_LOCK; m_good = 0;
      end else if (old == S_LOCK && good_r) begin
        m_good++;
        if (m_good >= LOCKN) begin m_state = S_OK; m_miss = 0; end
      end else if (old == S_LOCK && (rise || to)) begin
        m_good = 0; m_pulse = 1;
      end else if (old == S_OK && good_r) begin
        m_miss = 0;
      end else if (old == S_OK && (rise || to)) begin
        m_pulse = 1; m_miss++;
        if (m_miss >= MISSN) m_state = S_FAULT;
      end else if (old == S_FAULT && c) begin
        m_state = S_ACQ; m_last = cyc; m_good = 0; m_miss = 0;
      end
    end
    #1;
    if (wd_miss) miss_q.push_back(cyc);
  endtask
  task automatic gap_pulse(input int g);
    repeat (g - 1) step(0, 0, 0);
    step(1, 0, 0);
  endtask
  task automatic lock_up();
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    repeat (4) gap_pulse(251);
  endtask
  task automatic test_reset();
    step(0, 0, 1);
    step(0, 0, 1);
    checks++; if (wd_ok !== 1'b0) begin errors++; $display("FAIL reset_ok: got %b expected 0", wd_ok); end
    checks++; if (wd_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b expected 0", wd_fault); end
    checks++; if (wd_miss !== 1'b0) begin errors++; $display("FAIL reset_miss: got %b expected 0", wd_miss); end
    checks++; if (wd_period !== 9'd0) begin errors++; $display("FAIL reset_period: got %0d expected 0", wd_period); end
    checks++; if (wd_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", wd_state); end
  endtask
  task automatic test_lock();
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    checks++; if (wd_state !== 2'd1) begin errors++; $display("FAIL lock_first_rise: state %0d expected 1", wd_state); end
    for (int k = 2; k <= 5; k++) begin
      gap_pulse(251);
      checks++; if (wd_ok !== (k == 5)) begin errors++; $display("FAIL lock_ok_rise%0d: got %b expected %b", k, wd_ok, k == 5); end
    end
    checks++; if (wd_period !== 9'd251) begin errors++; $display("FAIL lock_period: got %0d expected 251", wd_period); end
    checks++; if (wd_state !== 2'd2) begin errors++; $display("FAIL lock_state: got %0d expected 2", wd_state); end
  endtask
  task automatic test_tolerance();
    gap_pulse(247);
    checks++; if (wd_miss !== 1'b0 || wd_period !== 9'd247) begin errors++; $display("FAIL tol_247: miss %b period %0d expected 0/247", wd_miss, wd_period); end
    gap_pulse(255);
    checks++; if (wd_miss !== 1'b0 || wd_period !== 9'd255) begin errors++; $display("FAIL tol_255: miss %b period %0d expected 0/255", wd_miss, wd_period); end
    repeat (255) step(0, 0, 0);
    checks++; if (wd_miss !== 1'b1) begin errors++; $display("FAIL tol_timeout_miss: got %b expected 1", wd_miss); end
    checks++; if (wd_period !== 9'd255) begin errors++; $display("FAIL tol_timeout_period: got %0d expected 255", wd_period); end
    step(1, 0, 0);
    checks++; if (wd_period !== 9'd1) begin errors++; $display("FAIL tol_late_period: got %0d expected 1", wd_period); end
    checks++; if (wd_state !== (EARLY ? 2'd3 : 2'd2)) begin errors++; $display("FAIL tol_late_state: got %0d expected %0d", wd_state, EARLY ? 3 : 2); end
  endtask
  task automatic test_early();
    lock_up();
    gap_pulse(100);
    checks++; if (wd_miss !== EARLY) begin errors++; $display("FAIL early_miss: got %b expected %b", wd_miss, EARLY); end
    checks++; if (wd_period !== 9'd100) begin errors++; $display("FAIL early_period: got %0d expected 100", wd_period); end
    checks++; if (wd_state !== 2'd2) begin errors++; $display("FAIL early_state: got %0d expected 2", wd_state); end
  endtask
  task automatic test_stop();
    int last;
    lock_up();
    last = cyc;
    miss_q.delete();
    repeat (520) begin
      step(0, 0, 0);
      if (cyc == last + 510) begin
        checks++; if (wd_fault !== 1'b1 || wd_ok !== 1'b0) begin errors++; $display("FAIL stop_fault: fault %b ok %b expected 1/0", wd_fault, wd_ok); end
      end
    end
    checks++;
    if (miss_q.size() != 2) begin
      errors++; $display("FAIL stop_miss_count: got %0d expected 2", miss_q.size());
    end else if (miss_q[0] != last + 255 || miss_q[1] != last + 510) begin
      errors++; $display("FAIL stop_miss_time: got +%0d,+%0d expected +255,+510", miss_q[0] - last, miss_q[1] - last);
    end
    checks++; if (wd_state !== 2'd3) begin errors++; $display("FAIL stop_state: got %0d expected 3", wd_state); end
  endtask
  task automatic test_clr();
    step(1, 1, 0);
    checks++; if (wd_state !== 2'd0 || wd_fault !== 1'b0) begin errors++; $display("FAIL clr_state: state %0d fault %b expected 0/0", wd_state, wd_fault); end
    repeat (3) step(0, 0, 0);
    step(1, 0, 0);
    checks++; if (wd_state !== 2'd1) begin errors++; $display("FAIL clr_relock: got %0d expected 1", wd_state); end
  endtask
  task automatic test_rst_mid();
    lock_up();
    repeat (20) step(0, 0, 0);
    step(0, 0, 1);
    checks++; if ({wd_ok, wd_fault, wd_miss, wd_period, wd_state} !== 14'd0) begin
      errors++; $display("FAIL rst_mid: ok %b fault %b miss %b period %0d state %0d expected all 0", wd_ok, wd_fault, wd_miss, wd_period, wd_state);
    end
  endtask
  function automatic int pick_gap();
    int r = $urandom % 10;
    if (r < 6) return $urandom_range(247, 255);
    if (r < 8) return 251;
    if (r == 8) return $urandom_range(1, 246);
    return $urandom_range(256, 400);
  endfunction
  task automatic test_random();
    int left = 10;
    bit hold = 0;
    step(0, 0, 1);
    for (int i = 0; i < 12000; i++) begin
      bit s, c, r;
      left--;
      s = (left == 0) | hold;
      hold = 0;
      if (left == 0) begin hold = ($urandom % 4 == 0); left = pick_gap(); end
      c = ($urandom % 40 == 0);
      r = ($urandom % 3000 == 0);
      step(s, c, r);
      checks++;
      if ({wd_state, wd_ok, wd_fault, wd_miss, wd_period} !== {2'(m_state), m_state == S_OK, m_state == S_FAULT, m_pulse, 9'(m_period)}) begin
        errors++;
        $display("FAIL random cyc %0d: state %0d ok %b fault %b miss %b period %0d expected %0d %b %b %b %0d", cyc,
                 wd_state, wd_ok, wd_fault, wd_miss, wd_period, m_state, m_state == S_OK, m_state == S_FAULT, m_pulse, m_period);
      end
    end
  endtask
  initial begin
    test_reset();
    test_lock();
    test_tolerance();
    test_early();
    test_stop();
    test_clr();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
